// File: rtl/bnn_pkg.sv
// Shared image geometry and loader state encoding for the BNN image front end.
package bnn_pkg;
  localparam int IMG_BITS  = 904;
  localparam int IMG_BYTES = IMG_BITS / 8;
  localparam int CNT_W     = 7;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    RUN   = 3'd1,
    CLEAR = 3'd2,
    HOLD  = 3'd3,
    ABORT = 3'd4
  } ldr_state_e;
endpackage

// File: rtl/img_byte_packer.sv
// Packs a byte stream MSB-first into an image word; done pulses (combinationally)
// with the write of the final byte so the FSM can register the transition.
module img_byte_packer
  import bnn_pkg::*;
#(
  parameter int IMG_BITS  = bnn_pkg::IMG_BITS,
  parameter int IMG_BYTES = bnn_pkg::IMG_BYTES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [7:0]          byte_in,
  output logic [IMG_BITS-1:0] img,
  output logic                done
);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IMG_BITS-1:0] img_q, img_d;

  always_comb begin
    cnt_d = cnt_q;
    img_d = img_q;
    done  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (wr_en) begin
      // Constant-index decode keeps the write mux a plain one-hot select.
      for (int k = 0; k < IMG_BYTES; k++) begin
        if (cnt_q == CNT_W'(k)) img_d[IMG_BITS-1-8*k -: 8] = byte_in;
      end
      if (cnt_q == CNT_W'(IMG_BYTES-1)) begin
        cnt_d = '0;
        done  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      img_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      img_q <= img_d;
    end
  end

  assign img = img_q;

endmodule

// File: rtl/img_loader_ctrl.sv
// Image loader: collects one image of bytes, hands it to the inference core,
// captures the class result and holds it until the host acknowledges.
module img_loader_ctrl
  import bnn_pkg::*;
#(
  parameter int IMG_BITS  = bnn_pkg::IMG_BITS,
  parameter int IMG_BYTES = bnn_pkg::IMG_BYTES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  output logic                byte_ready,
  input  logic                soft_clear,
  output logic [IMG_BITS-1:0] img_out,
  output logic                img_buffer_full,
  output logic                bnn_enable,
  output logic                bnn_clear,
  input  logic                result_ready,
  input  logic [3:0]          result_in,
  output logic [3:0]          result_out,
  output logic                result_valid,
  input  logic                result_ack
);

  ldr_state_e state_q, state_d;
  logic       byte_ready_q, byte_ready_d;
  logic       img_full_q, img_full_d;
  logic       bnn_en_q, bnn_en_d;
  logic       bnn_clr_q, bnn_clr_d;
  logic       res_vld_q, res_vld_d;
  logic [3:0] res_out_q, res_out_d;
  logic       accept, pk_clr, pk_done;

  // byte_ready is only ever high in LOAD, so it doubles as the state qualifier.
  assign accept = byte_valid && byte_ready_q && !soft_clear;
  assign pk_clr = soft_clear || (state_q == ABORT);

  img_byte_packer #(.IMG_BITS(IMG_BITS), .IMG_BYTES(IMG_BYTES)) u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (pk_clr),
    .wr_en   (accept),
    .byte_in (byte_in),
    .img     (img_out),
    .done    (pk_done)
  );

  always_comb begin
    state_d   = state_q;
    res_out_d = res_out_q;
    unique case (state_q)
      LOAD:  if (!soft_clear && pk_done) state_d = RUN;
      RUN: begin
        if (soft_clear) state_d = ABORT;
        else if (result_ready) begin
          res_out_d = result_in;
          state_d   = CLEAR;
        end
      end
      CLEAR: state_d = soft_clear ? ABORT : (result_ack ? LOAD : HOLD);
      HOLD:  state_d = soft_clear ? ABORT : (result_ack ? LOAD : HOLD);
      ABORT: state_d = LOAD;
      default: state_d = LOAD;
    endcase

    // Outputs are decoded from the next state so they are registered with it.
    byte_ready_d = (state_d == LOAD);
    img_full_d   = (state_d == RUN);
    bnn_en_d     = (state_d == RUN);
    bnn_clr_d    = (state_d == CLEAR) || (state_d == ABORT);
    res_vld_d    = (state_d == CLEAR) || (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      byte_ready_q <= 1'b0;
      img_full_q   <= 1'b0;
      bnn_en_q     <= 1'b0;
      bnn_clr_q    <= 1'b0;
      res_vld_q    <= 1'b0;
      res_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= byte_ready_d;
      img_full_q   <= img_full_d;
      bnn_en_q     <= bnn_en_d;
      bnn_clr_q    <= bnn_clr_d;
      res_vld_q    <= res_vld_d;
      res_out_q    <= res_out_d;
    end
  end

  assign byte_ready      = byte_ready_q;
  assign img_buffer_full = img_full_q;
  assign bnn_enable      = bnn_en_q;
  assign bnn_clear       = bnn_clr_q;
  assign result_valid    = res_vld_q;
  assign result_out      = res_out_q;

endmodule

// File: doc/img_loader_ctrl.md
IMG_LOADER_CTRL -- requirements
Module: img_loader_ctrl

Interface
REQ-001 SHALL have parameter IMG_BITS, default 904, image buffer width in bits.
REQ-002 SHALL have parameter IMG_BYTES, default 113 (IMG_BITS/8), bytes per image.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port byte_in  input  8  incoming image byte.
REQ-006 SHALL have port byte_valid  input  1  byte_in valid.
REQ-007 SHALL have port byte_ready  output  1  block accepts byte this cycle.
REQ-008 SHALL have port soft_clear  input  1  synchronous flush request.
REQ-009 SHALL have port img_out  output  IMG_BITS  assembled image to inference interface.
REQ-010 SHALL have port img_buffer_full  output  1  img_out holds a complete image.
REQ-011 SHALL have port bnn_enable  output  1  start/hold inference.
REQ-012 SHALL have port bnn_clear  output  1  one-cycle pulse returning inference interface to idle.
REQ-013 SHALL have port result_ready  input  1  inference result available.
REQ-014 SHALL have port result_in  input  4  inference class index.
REQ-015 SHALL have port result_out  output  4  captured class index.
REQ-016 SHALL have port result_valid  output  1  result_out valid to host.
REQ-017 SHALL have port result_ack  input  1  host consumed result.

Function
REQ-018 SHALL implement FSM states LOAD, RUN, CLEAR, HOLD, ABORT; all outputs registered.
REQ-019 LOAD: byte_ready=1; byte accepted when byte_valid&&byte_ready; byte counter (7 bits, 0..IMG_BYTES-1) increments per accept.
REQ-020 Byte k (0-based, arrival order) SHALL be written to img_out[IMG_BITS-1-8k -: 8]; first byte lands in img_out[903:896], last in img_out[7:0].
REQ-021 On acceptance of byte IMG_BYTES-1: counter->0, next state RUN; byte_ready SHALL be 0 the following cycle (no 114th byte accepted).
REQ-022 RUN: img_buffer_full=1, bnn_enable=1, byte_ready=0; img_out frozen; wait for result_ready.
REQ-023 RUN with result_ready=1: capture result_in into result_out same edge, next state CLEAR.
REQ-024 CLEAR: bnn_clear=1 for exactly one cycle, img_buffer_full=0, bnn_enable=0, result_valid=1; next state HOLD.
REQ-025 HOLD: result_valid=1, result_out stable; result_ready ignored (it stays high one cycle after bnn_clear); on result_ack -> result_valid=0 next cycle, state LOAD.
REQ-026 result_ack outside HOLD/CLEAR SHALL be ignored; result_ack in CLEAR SHALL be honoured (go LOAD directly, bnn_clear pulse still issued).
REQ-027 soft_clear SHALL have highest priority in every state: LOAD -> counter 0, stay LOAD; RUN/CLEAR/HOLD -> ABORT.
REQ-028 ABORT: bnn_clear=1 one cycle, bnn_enable=0, img_buffer_full=0, result_valid=0, counter 0; next state LOAD. A byte presented with soft_clear SHALL be dropped.
REQ-029 Latency: last byte accept edge -> bnn_enable high after 1 cycle; result_ready sampled -> result_valid high after 1 cycle.

Reset
REQ-030 rst_n low SHALL asynchronously force: state LOAD, counter 0, img_out 0, result_out 0, byte_ready 0, img_buffer_full 0, bnn_enable 0, bnn_clear 0, result_valid 0.
REQ-031 byte_ready SHALL rise on first clk edge after rst_n deasserts.
REQ-032 Reset mid-image SHALL discard partial image; loading restarts at byte 0.

Structure
REQ-033 IMG_BITS, IMG_BYTES and the loader state enum SHALL live in shared package bnn_pkg.
REQ-034 Byte-to-word packing SHALL be sub-module img_byte_packer (counter + shift/write, done flag); FSM stays in img_loader_ctrl.

Verification
REQ-035 Reset, 113 bytes 0x00..0x70 back-to-back -> img_out[903:896]=0x00, img_out[7:0]=0x70, bnn_enable=1 one cycle after last byte.
REQ-036 In RUN, result_ready=1 with result_in=4'd7 -> result_out=7, result_valid=1, bnn_clear single pulse next cycle.
REQ-037 HOLD with result_ready held high 3 cycles, no ack -> no second bnn_clear, result_valid stays 1; ack -> LOAD, byte_ready=1.
REQ-038 byte_valid toggled randomly, 113 accepts -> exactly 113 writes, 114th byte not accepted.
REQ-039 soft_clear during RUN -> bnn_clear pulse, bnn_enable 0, result_valid 0, next 113 bytes start at img_out[903:896].
REQ-040 rst_n low after 50 bytes -> all outputs 0 immediately; reload of 113 bytes completes normally.
